// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared encodings for the pipeline sequencing controller.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package hazard_stall_ctrl_pkg;

    // Load-type encoding that marks an EXE-stage instruction as "not a load".
    localparam logic [2:0] DMRD_NOP = 3'b000;

    // Mult/div sequencer states.
    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_t;

    // True when an operand field is actually read and names the given register.
    function automatic logic reg_match(input logic       use_r,
                                       input logic [4:0] src,
                                       input logic [4:0] dst);
        return use_r && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_seq.sv
// Mult/div occupancy sequencer: IDLE -> BUSY (countdown) -> DONE -> IDLE.
// Latency: occupancy from the start cycle to the done cycle is MULT_CYCLES or DIV_CYCLES.
// Backpressure: start is only accepted in IDLE; requests in BUSY/DONE are ignored.
module hazard_stall_ctrl_md_seq
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32
) (
    input  logic clk,
    input  logic rstn,
    input  logic start,
    input  logic div,
    output logic busy,
    output logic done
);

    localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    // The start cycle and the done cycle are part of the occupancy, so the
    // countdown only covers the BUSY cycles in between.
    localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES - 2);
    localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES - 2);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    md_state_t      state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [CW-1:0]  ld_val;

    // Next-state and countdown decode.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ld_val    = div ? DIV_LD : MULT_LD;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    cnt_nxt   = ld_val;
                    // A 2-cycle operation has no BUSY cycles at all.
                    state_nxt = (ld_val == '0) ? MD_DONE : MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (cnt == CNT_ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = MD_DONE;
                end else begin
                    cnt_nxt   = cnt - CNT_ONE;
                end
            end
            MD_DONE: begin
                state_nxt = MD_IDLE;
            end
            default: begin
                state_nxt = MD_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and countdown registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign busy = (state != MD_IDLE);
    assign done = (state == MD_DONE);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall controller: load-use and HI/LO stalls, branch flush, mult/div sequencing.
// Latency: stall/flush/start are combinational; MD_busy/MD_done decode registered state.
// Backpressure: holds PC and IF/ID while a hazard persists; a taken branch overrides any stall.
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       IFID_rs,
    input  logic [4:0]       IFID_rt,
    input  logic             IFID_use_rs,
    input  logic             IFID_use_rt,
    input  logic             IFID_HiLoUse,
    input  logic [2:0]       IDEXE_DMRd,
    input  logic [4:0]       IDEXE_rd,
    input  logic             IDEXE_MDStart,
    input  logic             IDEXE_MDDiv,
    input  logic             EXE_BrTaken,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IFID_flush,
    output logic             IDEXE_flush,
    output logic             MD_start,
    output logic             MD_busy,
    output logic             MD_done,
    output logic [CNT_W-1:0] stall_cnt
);

    logic md_req;
    logic md_occ;
    logic md_fin;
    logic start_ok;
    logic ld_haz;
    logic hl_haz;
    logic stall;

    // A wrong-path mult/div in EXE must not start the unit.
    assign md_req   = IDEXE_MDStart && !EXE_BrTaken;
    assign start_ok = md_req && !md_occ;

    hazard_stall_ctrl_md_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) u_md_seq (
        .clk   (clk),
        .rstn  (rstn),
        .start (md_req),
        .div   (IDEXE_MDDiv),
        .busy  (md_occ),
        .done  (md_fin)
    );

    // Load result is not forwardable until the load reaches MEM; $0 never hazards.
    assign ld_haz = (IDEXE_DMRd != DMRD_NOP) && (IDEXE_rd != 5'd0) &&
                    (reg_match(IFID_use_rs, IFID_rs, IDEXE_rd) ||
                     reg_match(IFID_use_rt, IFID_rt, IDEXE_rd));

    // HI/LO users wait through DONE so they see the written result.
    assign hl_haz = IFID_HiLoUse && (start_ok || md_occ);

    assign stall  = (ld_haz || hl_haz) && !EXE_BrTaken;

    // Combinational outputs are forced low while reset is held.
    assign PC_stall    = rstn && stall;
    assign IFID_stall  = rstn && stall;
    assign IFID_flush  = rstn && EXE_BrTaken;
    assign IDEXE_flush = rstn && (stall || EXE_BrTaken);
    assign MD_start    = rstn && start_ok;
    assign MD_busy     = md_occ;
    assign MD_done     = md_fin;

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage CPU; sits beside the forwarding logic in the ID/EXE boundary.
- Covers hazards that forwarding cannot resolve: load-use, HI/LO access while the multi-cycle mult/div unit is busy, and taken-branch/jump flush.
- Generates PC/IFID hold, IFID/IDEXE flush, and mult/div start/busy/done sequencing.
- Keeps a saturating stall-cycle performance counter.

Parameters:
MULT_CYCLES, 4, cycles a mult/multu occupies the mult/div unit (>=2)
DIV_CYCLES, 32, cycles a div/divu occupies the mult/div unit (>=2)
CNT_W, 16, width of stall performance counter

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  reset; asynchronous assert, active-low
IFID_rs  in  5  rs field of instruction in ID
IFID_rt  in  5  rt field of instruction in ID
IFID_use_rs  in  1  ID instruction reads rs as a register operand
IFID_use_rt  in  1  ID instruction reads rt as a register operand
IFID_HiLoUse  in  1  ID instruction is mfhi/mflo/mthi/mtlo or mult/div
IDEXE_DMRd  in  3  EXE-stage load type; `DMRd_NOP means not a load
IDEXE_rd  in  5  EXE-stage destination register
IDEXE_MDStart  in  1  EXE-stage instruction is mult/multu/div/divu
IDEXE_MDDiv  in  1  1 = div/divu, 0 = mult/multu (valid with IDEXE_MDStart)
EXE_BrTaken  in  1  branch/jump resolved taken in EXE this cycle
PC_stall  out  1  hold PC
IFID_stall  out  1  hold IF/ID register
IFID_flush  out  1  zero IF/ID register
IDEXE_flush  out  1  insert bubble into ID/EXE
MD_start  out  1  one-cycle start pulse to mult/div datapath
MD_busy  out  1  mult/div unit occupied
MD_done  out  1  one-cycle pulse: HI/LO written at end of this cycle
stall_cnt  out  CNT_W  number of cycles PC_stall was 1, saturating

Behaviour:
- Reset (rstn=0, async): FSM=IDLE, countdown=0, stall_cnt=0. All outputs are 0 while rstn=0, including the combinational ones.
- Mult/div FSM, states IDLE, BUSY, DONE:
  - IDLE: IDEXE_MDStart=1 and EXE_BrTaken=0 gives MD_start=1 (combinational, same cycle). Next state BUSY; countdown loads (IDEXE_MDDiv ? DIV_CYCLES : MULT_CYCLES) - 2.
  - BUSY: MD_busy=1. Countdown decrements each cycle; when it reaches 0, next state is DONE.
  - DONE: MD_busy=1, MD_done=1. Next state IDLE. Another mult/div in EXE in this cycle cannot occur, because ID stalls HI/LO users (below).
  - IDEXE_MDStart outside IDLE is ignored (no restart, no effect on countdown).
  - Total occupancy from the MD_start cycle to the MD_done cycle inclusive = MULT_CYCLES or DIV_CYCLES.
- Load-use hazard:
  - ld_haz = (IDEXE_DMRd != `DMRd_NOP) && (IDEXE_rd != 0) && ((IFID_use_rs && IFID_rs == IDEXE_rd) || (IFID_use_rt && IFID_rt == IDEXE_rd)).
  - Lasts exactly one cycle; the next cycle the load is in MEM and forwarding covers it.
- HI/LO hazard: hl_haz = IFID_HiLoUse && (MD_start || FSM != IDLE).
  - Includes DONE: a stalled mfhi/mflo is released the cycle after MD_done.
- Outputs:
  - stall = (ld_haz || hl_haz) && !EXE_BrTaken.
  - PC_stall = IFID_stall = stall.
  - IDEXE_flush = stall || EXE_BrTaken.
  - IFID_flush = EXE_BrTaken.
- Priority: a taken branch overrides any stall, because the ID instruction is wrong-path. An in-flight mult/div (already past EXE) is never cancelled by a flush.
- stall_cnt increments on every clock edge with PC_stall=1. It holds at 2^CNT_W-1 and does not wrap.
- All stall/flush/start outputs are combinational from the current inputs and FSM state; MD_busy and MD_done decode from the registered state.

Decomposition:
- Shared package/define file (the existing ctrl_encode_def include) gains the FSM state encodings MD_IDLE/MD_BUSY/MD_DONE (2 bits) and reuses `DMRd_NOP.
- One natural sub-module: md_seq (FSM + countdown, ports clk/rstn/start/div/busy/done). Hazard decode stays in the top.

Test Plan:
- Load-use: EXE lw with IDEXE_rd=8, ID add with rs=8, use_rs=1 -> PC_stall=IFID_stall=IDEXE_flush=1 for exactly 1 cycle; stall_cnt 0->1. Same with IDEXE_rd=0 -> no stall.
- Mult timing: IDEXE_MDStart=1, MDDiv=0 at cycle T -> MD_start=1 at T; MD_busy=1 T+1..T+3; MD_done=1 at T+3; IDLE at T+4.
- HI/LO stall: div started at T, ID holds mflo from T+1 -> PC_stall=1 for T+1..T+31, deasserted at T+32; stall_cnt=31.
- Branch priority: ld_haz=1 and EXE_BrTaken=1 in the same cycle -> PC_stall=0, IFID_flush=1, IDEXE_flush=1, stall_cnt unchanged. Branch during BUSY -> countdown continues, MD_done still fires on schedule.
- Reset mid-divide: rstn low at cycle 10 of a div -> MD_busy=0 and stall_cnt=0 immediately (async); after release, FSM is in IDLE and a new mult completes in 4 cycles.
- Saturation: with CNT_W=4, force 20 stall cycles -> stall_cnt=15 and holds.
